fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the program counter of the image-filter processor and drives the instruction-memory port. It issues word fetches with a req/ack handshake, presents each fetched instruction with its PC to decode, and handles pipeline stalls, branch/jump redirects and the halt instruction. It sits between the instruction memory and the decode stage and replaces free-running per-cycle PC updates with a controlled fetch sequence.

---
 rtl/fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_fetch_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the program counter, issues
// req/ack word fetches to instruction memory, and hands each fetched word and
// its address to decode. Handles stalls, branch/jump redirects and halt.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] ipc_reg, ipc_next;
  // squash: the outstanding request was overtaken by a redirect; drop its data.
  logic        squash_reg, squash_next;
  // halt_pend: halt seen while a request is outstanding; stop on its ack.
  logic        hpend_reg, hpend_next;

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      addr_reg   <= 32'h0000_0000;
      instr_reg  <= 32'h0000_0000;
      ipc_reg    <= 32'h0000_0000;
      squash_reg <= 1'b0;
      hpend_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      addr_reg   <= addr_next;
      instr_reg  <= instr_next;
      ipc_reg    <= ipc_next;
      squash_reg <= squash_next;
      hpend_reg  <= hpend_next;
    end
  end

  // Next-state and datapath updates; everything holds unless a branch below changes it.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    addr_next   = addr_reg;
    instr_next  = instr_reg;
    ipc_next    = ipc_reg;
    squash_next = squash_reg;
    hpend_next  = hpend_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = REQ;
          addr_next  = pc_reg;
        end
      end
      REQ: begin
        if (redirect) begin
          // Redirect beats halt. The address on the bus may only move once the
          // current request has been acknowledged.
          pc_next = redirect_pc;
          if (imem_ack) begin
            addr_next   = redirect_pc;
            squash_next = 1'b0;
          end else begin
            squash_next = 1'b1;
          end
        end else if (halt || hpend_reg) begin
          hpend_next = 1'b1;
          if (imem_ack) begin
            hpend_next  = 1'b0;
            squash_next = 1'b0;
            state_next  = HALT;
          end
        end else if (imem_ack) begin
          if (squash_reg) begin
            // Stale fetch completed; reissue at the redirected pc.
            squash_next = 1'b0;
            addr_next   = pc_reg;
          end else begin
            instr_next = imem_rdata;
            ipc_next   = addr_reg;
            pc_next    = addr_reg + PC_INC;
            state_next = OUT;
          end
        end
      end
      OUT: begin
        if (redirect) begin
          pc_next    = redirect_pc;
          addr_next  = redirect_pc;
          state_next = REQ;
        end else if (halt) begin
          state_next = HALT;
        end else if (!stall) begin
          addr_next  = pc_reg;
          state_next = REQ;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs come straight from registers, so there is no input-to-output path.
  assign imem_req    = (state_reg == REQ);
  assign imem_addr   = addr_reg;
  assign instr       = instr_reg;
  assign instr_pc    = ipc_reg;
  assign instr_valid = (state_reg == OUT);
  assign busy        = (state_reg == REQ) || (state_reg == OUT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. Memory responses are driven by
// the bench; each kept fetch pushes its expected {pc, instr} into a scoreboard
// that is popped when decode sees instr_valid.
module tb_fetch_ctrl;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0)
  logic        rst = 1'b1, start = 1'b0, stall = 1'b0, redirect = 1'b0, halt = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req, instr_valid, busy;
  logic [31:0] imem_addr, instr, instr_pc;

  // Wrap instance (RESET_PC = FFFF_FFFC)
  logic        rst2 = 1'b1, start2 = 1'b0, ack2 = 1'b0;
  logic [31:0] rdata2 = 32'h0;
  logic        req2, valid2, busy2;
  logic [31:0] addr2, instr2, ipc2;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .busy(busy)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .PC_INC(32'd4)) dut_wrap (
    .clk(clk), .rst(rst2), .start(start2), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .halt(1'b0), .imem_req(req2),
    .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .instr(instr2), .instr_pc(ipc2), .instr_valid(valid2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_main(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_instr"}, instr, 0);
    check({tag, "_ipc"}, instr_pc, 0);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Entered on a negedge where the DUT should be requesting exp_addr.
  // Holds the ack back for lat cycles, then acks; keep=1 pushes the expectation.
  task automatic serve(input logic [31:0] exp_addr, input int lat, input bit keep);
    check("req_valid_low", instr_valid, 0);
    check("req_busy", busy, 1);
    check("req", imem_req, 1);
    check("req_addr", imem_addr, exp_addr);
    for (int i = 0; i < lat; i++) begin
      tick();
      check("req_wait", imem_req, 1);
      check("req_wait_addr", imem_addr, exp_addr);
      check("req_wait_valid", instr_valid, 0);
    end
    imem_ack   = 1'b1;
    imem_rdata = exp_addr ^ KEY;
    if (keep) sb.push_back({exp_addr, exp_addr ^ KEY});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  // Entered on the negedge right after an accepted ack.
  task automatic expect_out();
    logic [63:0] e;
    check("out_valid", instr_valid, 1);
    check("out_req_low", imem_req, 0);
    check("out_busy", busy, 1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed no entry expected one at pc %h", instr_pc);
    end else begin
      e = sb.pop_front();
      check("out_pc", instr_pc, e[63:32]);
      check("out_instr", instr, e[31:0]);
      $display("fetch pc=%h instr=%h", e[63:32], e[31:0]);
    end
  endtask

  initial begin
    // Reset
    tick(); tick();
    check_reset_main("rst0");
    rst = 1'b0;

    // Zero-wait fetches at 0, 4, 8
    start = 1'b1;
    tick();
    start = 1'b0;
    serve(32'h0, 0, 1); expect_out(); tick();
    serve(32'h4, 0, 1); expect_out(); tick();
    serve(32'h8, 0, 1); expect_out();

    // Stall 4 cycles at pc 8: output held 5 cycles, no request
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("stall_valid", instr_valid, 1);
      check("stall_pc", instr_pc, 32'h8);
      check("stall_instr", instr, 32'h8 ^ KEY);
      check("stall_req", imem_req, 0);
    end
    stall = 1'b0;
    tick();

    // Delayed ack: request held 3 cycles at pc 12
    serve(32'hC, 2, 1); expect_out(); tick();

    // Redirect in REQ at 0x10, ack two cycles later is discarded
    check("rd_req", imem_req, 1);
    check("rd_addr", imem_addr, 32'h10);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0; redirect_pc = 32'h0;
    check("rd_hold_req", imem_req, 1);
    check("rd_hold_addr", imem_addr, 32'h10);
    tick();
    check("rd_hold2_addr", imem_addr, 32'h10);
    check("rd_hold2_valid", instr_valid, 0);
    imem_ack = 1'b1; imem_rdata = 32'h10 ^ KEY;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    serve(32'h100, 0, 1); expect_out();

    // Redirect in OUT to 0x20, then halt there
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0; redirect_pc = 32'h0;
    serve(32'h20, 0, 1); expect_out();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_req", imem_req, 0);
    check("halt_valid", instr_valid, 0);
    check("halt_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("halt_start_req", imem_req, 0);
    check("halt_start_busy", busy, 0);
    tick();
    check("halt_start2_req", imem_req, 0);

    // Reset out of HALT restarts from RESET_PC
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_main("rst1");
    start = 1'b1;
    tick();
    start = 1'b0;
    serve(32'h0, 0, 1); expect_out(); tick();
    check("sb_drained", sb.size(), 0);

    // Wrap instance: FFFF_FFFC then 0; reset with a coincident ack
    rst2 = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("w_req", req2, 1);
    check("w_addr", addr2, 32'hFFFF_FFFC);
    ack2 = 1'b1; rdata2 = 32'hFFFF_FFFC ^ KEY;
    tick();
    ack2 = 1'b0; rdata2 = 32'h0;
    check("w_valid", valid2, 1);
    check("w_pc", ipc2, 32'hFFFF_FFFC);
    check("w_instr", instr2, 32'hFFFF_FFFC ^ KEY);
    $display("wrap fetch pc=%h instr=%h", ipc2, instr2);
    tick();
    check("w_req2", req2, 1);
    check("w_addr2", addr2, 32'h0);
    rst2 = 1'b1; ack2 = 1'b1; rdata2 = 32'h1234_5678;
    tick();
    rst2 = 1'b0; ack2 = 1'b0; rdata2 = 32'h0;
    check("w_rst_req", req2, 0);
    check("w_rst_addr", addr2, 0);
    check("w_rst_instr", instr2, 0);
    check("w_rst_ipc", ipc2, 0);
    check("w_rst_valid", valid2, 0);
    check("w_rst_busy", busy2, 0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("w_restart_addr", addr2, 32'hFFFF_FFFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
